// File: rtl/or_share_pkg.sv
// Shared types and helpers for the round-robin OR arbiter.
package or_share_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pointer moves to the requester just after the winner, wrapping to 0.
  function automatic int next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/or_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module or_rr_picker
  import or_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        off;
  logic [ID_W:0]        sum;

  // Rotate the request vector so ptr sits at bit 0, priority-encode the
  // lowest set bit, then rotate the offset back into a requester index.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    gnt_valid = 1'b0;
    off       = '0;
    dbl       = {req_valid, req_valid};
    rot       = NUM_REQ'(dbl >> ptr);
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_valid = 1'b1;
        off       = (ID_W + 1)'(j);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (ID_W + 1)'(NUM_REQ)) begin
      sum = sum - (ID_W + 1)'(NUM_REQ);
    end
    gnt_idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/or_share_arbiter.sv
// Round-robin arbiter sharing one registered OR datapath among requesters.
module or_share_arbiter
  import or_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

  state_e           state;
  logic [ID_W-1:0]  ptr;
  logic             load_en;
  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  or_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The result register may load when empty or when it drains this cycle.
  assign load_en = !reset && (state == ST_EMPTY || out_ready);

  // Ready only to the winner, and only when its pair can actually be stored.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = load_en && gnt_valid && (gnt_idx == ID_W'(i));
    end
  end

  // Steer the winner's operands; lanes that are not selected never reach the OR.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // EMPTY/FULL state machine owning the result register and the rr pointer.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= ST_EMPTY;
      ptr    <= '0;
      out_y  <= '0;
      out_id <= '0;
    end else if (load_en) begin
      if (gnt_valid) begin
        state  <= ST_FULL;
        out_y  <= sel_a | sel_b;
        out_id <= gnt_idx;
        ptr    <= ID_W'(next_ptr(int'(gnt_idx), NUM_REQ));
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

  assign out_valid = (state == ST_FULL);
  assign busy      = out_valid;

endmodule

// File: tb/tb_or_share_arbiter.sv
// Self-checking bench: random plus directed stimulus, scoreboard on the output.
module tb_or_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] y;
    int           id;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_y;
  logic [1:0]     out_id;
  logic           busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  // Reference model state: queue occupancy flag and rr pointer as plain ints.
  bit   m_known       = 1'b0;
  bit   m_full        = 1'b0;
  bit   m_after_reset = 1'b0;
  int   m_ptr         = 0;

  or_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, check combinational/status outputs against the
  // model, then advance the model as if the upcoming edge happened.
  task automatic cycle(input logic rst, input logic [N-1:0] rv, input logic ordy,
                       input logic [N*W-1:0] av, input logic [N*W-1:0] bv);
    int           g;
    bit           found;
    bit           load;
    logic [N-1:0] exp_rr;
    exp_t         e;
    @(posedge clock);
    #1;
    reset     = rst;
    req_valid = rv;
    out_ready = ordy;
    req_a     = av;
    req_b     = bv;
    #1;
    if (m_known) begin
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("busy", 32'(busy), 32'(m_full));
    end
    if (m_after_reset) begin
      check("out_y_after_reset", 32'(out_y), 32'h0);
      check("out_id_after_reset", 32'(out_id), 32'h0);
    end
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rv[(m_ptr + k) % N]) begin
        found = 1'b1;
        g     = (m_ptr + k) % N;
      end
    end
    load   = !rst && (!m_full || ordy);
    exp_rr = (load && found) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    m_after_reset = rst;
    if (rst) begin
      sb.delete();
      m_full  = 1'b0;
      m_ptr   = 0;
      m_known = 1'b1;
    end else if (load) begin
      if (found) begin
        e.y   = av[g*W +: W] | bv[g*W +: W];
        e.id  = g;
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (g + 1) % N;
      end else begin
        m_full = 1'b0;
      end
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty_on_output", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_out_y", 32'(out_y), 32'(e.y));
          check("sb_out_id", 32'(out_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] rr_a;
    logic [N*W-1:0] rr_b;
    rr_a = {8'd3, 8'd2, 8'd1, 8'd0};
    rr_b = {4{8'h10}};

    // Reset held two cycles with every requester valid.
    cycle(1'b1, 4'b1111, 1'b1, '1, '1);
    cycle(1'b1, 4'b1111, 1'b1, '1, '1);

    // Single request from requester 2.
    cycle(1'b0, 4'b0100, 1'b1, 32'h000F_0000, 32'h00F0_0000);
    cycle(1'b0, 4'b0000, 1'b1, '0, '0);
    check("single_out_y", 32'(out_y), 32'hFF);
    check("single_out_id", 32'(out_id), 32'd2);

    // Round-robin from ptr 0 with all requesters valid.
    cycle(1'b1, 4'b0000, 1'b1, '0, '0);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) cycle(1'b0, 4'b1111, 1'b1, rr_a, rr_b);
      else       cycle(1'b0, 4'b0000, 1'b1, '0, '0);
      if (k >= 1) begin
        check("rr_out_id", 32'(out_id), 32'((k - 1) % 4));
        check("rr_out_y", 32'(out_y), 32'(8'h10 | 8'((k - 1) % 4)));
      end
    end

    // Backpressure: 0x55 from requester 1 held while out_ready is low.
    cycle(1'b0, 4'b0010, 1'b1, 32'h0000_5500, '0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'b1111, 1'b0, rr_a, rr_b);
      check("bp_out_y", 32'(out_y), 32'h55);
      check("bp_out_id", 32'(out_id), 32'd1);
    end
    cycle(1'b0, 4'b1111, 1'b1, rr_a, rr_b);

    // Wrap: ptr is 3, requesters 0 and 3 valid.
    cycle(1'b0, 4'b1001, 1'b1, rr_a, rr_b);
    check("bp_release_id", 32'(out_id), 32'd2);
    cycle(1'b0, 4'b1001, 1'b1, rr_a, rr_b);
    check("wrap_id3", 32'(out_id), 32'd3);
    cycle(1'b0, 4'b0000, 1'b1, '0, '0);
    check("wrap_id0", 32'(out_id), 32'd0);

    // Reset mid-operation discards the pending result and rewinds ptr.
    cycle(1'b0, 4'b0100, 1'b1, rr_a, rr_b);
    cycle(1'b0, 4'b0000, 1'b0, '0, '0);
    cycle(1'b1, 4'b0000, 1'b0, '0, '0);
    cycle(1'b0, 4'b1111, 1'b1, rr_a, rr_b);
    cycle(1'b0, 4'b0000, 1'b1, '0, '0);
    check("post_reset_id", 32'(out_id), 32'd0);

    // Randomized traffic with occasional backpressure and resets.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), N'($urandom), ($urandom_range(0, 9) < 7),
            {$urandom}, {$urandom});
    end

    // Drain and confirm every expected result was observed.
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0000, 1'b1, '0, '0);
    @(negedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/or_share_arbiter.md
Name: or_share_arbiter

Overview:
- Round-robin arbiter that shares one registered OR datapath (y = a | b) among NUM_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The winning pair is OR-ed and held in a single-entry output register, tagged with the requester index.
- Sits between multiple stimulus sources and the OR_Gate output interface (OR_out), which consumes out_y/out_id.

Parameters:
- NUM_REQ, 4, number of requesters (>=1)
- WIDTH, 8, operand/result width in bits (>=1)
- ID_W, derived = max(1, clog2(NUM_REQ)), width of out_id; not user-overridable

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream accepts result
- out_y  out  WIDTH  registered a|b of the granted requester
- out_id  out  ID_W  index of the requester that produced out_y
- busy  out  1  equals out_valid; status for sequencer/bench

Behaviour:
- Reset (synchronous, sampled at rising edge):
  - out_valid=0, out_y=0, out_id=0, ptr=0, state=EMPTY.
  - req_ready forced to all-0 combinationally while reset=1.
- FSM, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !reset && (state==EMPTY || out_ready).
  - A FULL register draining in the same cycle can reload.
- Round-robin pick: search req_valid from index ptr upward, wrapping modulo NUM_REQ; first set bit is g.
  - No valid bit means no grant.
- req_ready[g] = load_en when a grant exists; all other bits 0.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Handshake on requester g at edge k:
  - out_y <= a_g|b_g, out_id <= g, state <= FULL.
  - ptr <= (g==NUM_REQ-1) ? 0 : g+1.
  - Latency 1 cycle: result visible in cycle k+1.
- Transitions:
  - EMPTY with no grant -> EMPTY.
  - FULL with out_ready=1 and no grant -> EMPTY.
  - FULL with out_ready=1 and grant -> FULL (new data).
  - FULL with out_ready=0 -> FULL; out_y/out_id held stable, all req_ready=0.
- ptr changes only on a grant; it never moves on idle or stall cycles.
- Throughput: one result per cycle when out_ready is held high.
- Fairness: a continuously valid requester is granted within NUM_REQ successive grants.
- NUM_REQ=1: ptr stays 0, out_id=0 always, behaves as a 1-deep pipeline register.
- Reset mid-operation: any pending result is discarded without handshake; ptr returns to 0.
- No arithmetic beyond bitwise OR; out_y width equals WIDTH, with no truncation or extension.
- Inputs of non-granted requesters are ignored. X on an unselected lane must not propagate.

Decomposition:
- Package or_share_pkg:
  - state enum {ST_EMPTY, ST_FULL}
  - function id_width(n) returning max(1, clog2(n))
  - function next_ptr(g, n) implementing the wrap rule
- Sub-module or_rr_picker (combinational):
  - Inputs: req_valid, ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Implemented via double-width rotate/mask priority encode.
  - Unit-testable separately.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req_valid=4'b1111, out_ready=1 -> req_ready=0, out_valid=0, out_y=0, out_id=0 throughout.
- Single request (NUM_REQ=4, WIDTH=8): req_valid=4'b0100, a2=0x0F, b2=0xF0 -> req_ready=4'b0100 that cycle; next cycle out_valid=1, out_y=0xFF, out_id=2.
- Round-robin: req_valid=4'b1111 held, out_ready=1, a_i=i, b_i=0x10 -> out_id sequence 0,1,2,3,0 on consecutive cycles; out_y 0x10,0x11,0x12,0x13,0x10.
- Backpressure: result 0x55/id1 pending, out_ready=0 for 3 cycles, req_valid=4'b1111 -> out_y/out_id stable, req_ready=0. On out_ready=1 the same cycle shows req_ready=4'b0100, and the next cycle shows out_id=2.
- Wrap: grant id 2 (ptr=3), then req_valid=4'b1001 -> grant 3, then 0.
- Reset mid-op: out_valid=1 with out_ready=0, assert reset one cycle -> out_valid=0 next cycle, result never handshaken. Then req_valid=4'b1111 -> first grant id 0.
